instr_packer: RTL



---
 rtl/instr_packer_pkg.sv | 38 +++
 rtl/rvc_compressor.sv | 97 +++++++++
 rtl/instr_packer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/instr_packer_pkg.sv
// Shared RV32I/RVC encodings, packer state and byte order helper.
// Used by rvc_compressor and instr_packer (and the fetch path swap).
package instr_packer_pkg;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_W   = 3'b010;

  localparam logic [1:0] Q0 = 2'b00;
  localparam logic [1:0] Q1 = 2'b01;
  localparam logic [1:0] Q2 = 2'b10;

  localparam logic [2:0] CF3_ADDI = 3'b000;
  localparam logic [2:0] CF3_LI   = 3'b010;
  localparam logic [2:0] CF3_LW   = 3'b010;
  localparam logic [2:0] CF3_SW   = 3'b110;
  localparam logic [3:0] CF4_MV   = 4'b1000;
  localparam logic [3:0] CF4_ADD  = 4'b1001;

  localparam logic [15:0] C_NOP = 16'h0001;

  typedef enum logic [1:0] {
    EMPTY,
    HALF,
    PAD
  } state_t;

  function automatic logic [31:0] bswap32(
    input logic [31:0] w
  );
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/rvc_compressor.sv
// Maps a 32-bit RV32I instruction to RVC form over a small subset.
// Ports: instr in; is_comp flags a hit, c_instr holds the parcel.
module rvc_compressor
  import instr_packer_pkg::*;
(
  input  logic [31:0] instr,
  output logic        is_comp,
  output logic [15:0] c_instr
);

  logic [6:0]  opc;
  logic [4:0]  rd;
  logic [2:0]  f3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  f7;
  logic [11:0] imm_i;
  logic [11:0] imm_s;

  assign opc   = instr[6:0];
  assign rd    = instr[11:7];
  assign f3    = instr[14:12];
  assign rs1   = instr[19:15];
  assign rs2   = instr[24:20];
  assign f7    = instr[31:25];
  assign imm_i = instr[31:20];
  assign imm_s = {instr[31:25], instr[11:7]};

  logic is_addi, is_add, is_lw, is_sw;
  logic imm6_ok, imm_nz, lw_ok, sw_ok;

  assign is_addi = (opc == OP_IMM) && (f3 == F3_ADD);
  assign is_add  = (opc == OP) && (f3 == F3_ADD)
                && (f7 == 7'd0);
  assign is_lw   = (opc == LOAD) && (f3 == F3_W);
  assign is_sw   = (opc == STORE) && (f3 == F3_W);

  // imm fits 6-bit signed: upper bits all copies of bit 5
  assign imm6_ok = (&imm_i[11:5]) | ~(|imm_i[11:5]);
  assign imm_nz  = |imm_i;

  // word offset 0..124, registers in x8..x15
  assign lw_ok = (imm_i[11:7] == 5'd0)
              && (imm_i[1:0] == 2'd0)
              && (rd[4:3] == 2'b01)
              && (rs1[4:3] == 2'b01);
  assign sw_ok = (imm_s[11:7] == 5'd0)
              && (imm_s[1:0] == 2'd0)
              && (rs2[4:3] == 2'b01)
              && (rs1[4:3] == 2'b01);

  always_comb begin
    is_comp = 1'b0;
    c_instr = 16'h0000;
    unique case (1'b1)
      is_addi && rd == 5'd0 && rs1 == 5'd0
        && !imm_nz: begin
        is_comp = 1'b1;
        c_instr = C_NOP;
      end
      is_addi && rd != 5'd0 && rd == rs1
        && imm6_ok && imm_nz: begin
        is_comp = 1'b1;
        c_instr = {CF3_ADDI, imm_i[5], rd,
                   imm_i[4:0], Q1};
      end
      is_addi && rs1 == 5'd0 && rd != 5'd0
        && imm6_ok: begin
        is_comp = 1'b1;
        c_instr = {CF3_LI, imm_i[5], rd,
                   imm_i[4:0], Q1};
      end
      is_add && rd != 5'd0 && rd == rs1
        && rs2 != 5'd0: begin
        is_comp = 1'b1;
        c_instr = {CF4_ADD, rd, rs2, Q2};
      end
      is_add && rs1 == 5'd0 && rd != 5'd0
        && rs2 != 5'd0: begin
        is_comp = 1'b1;
        c_instr = {CF4_MV, rd, rs2, Q2};
      end
      is_lw && lw_ok: begin
        is_comp = 1'b1;
        c_instr = {CF3_LW, imm_i[5:3], rs1[2:0],
                   imm_i[2], imm_i[6], rd[2:0], Q0};
      end
      is_sw && sw_ok: begin
        is_comp = 1'b1;
        c_instr = {CF3_SW, imm_s[5:3], rs1[2:0],
                   imm_s[2], imm_s[6], rs2[2:0], Q0};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_packer.sv
// Compresses an RV32I stream and packs 16/32-bit parcels into words.
// Ports: in_* valid/ready stream in; out_* byte-swapped word out.
module instr_packer
  import instr_packer_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter bit COMPRESS_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last
);

  logic        comp_hit;
  logic [15:0] c_instr;

  rvc_compressor u_comp (
    .instr   (in_instr),
    .is_comp (comp_hit),
    .c_instr (c_instr)
  );

  state_t      state_q, state_d;
  logic [15:0] hold_q, hold_d;
  logic        load;
  logic [31:0] load_word;
  logic        load_last;
  logic        o_free, in_fire, is_c;

  assign is_c     = COMPRESS_EN && comp_hit;
  assign o_free   = !out_valid || out_ready;
  assign in_ready = o_free && (state_q != PAD);
  assign in_fire  = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    load      = 1'b0;
    load_word = 32'h0;
    load_last = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          if (is_c) begin
            hold_d  = c_instr;
            state_d = in_last ? PAD : HALF;
          end else begin
            load      = 1'b1;
            load_word = in_instr;
            load_last = in_last;
          end
        end
      end
      HALF: begin
        if (in_fire) begin
          load = 1'b1;
          if (is_c) begin
            load_word = {c_instr, hold_q};
            load_last = in_last;
            hold_d    = 16'h0;
            state_d   = EMPTY;
          end else begin
            // low half closes this word, high half carries over
            load_word = {in_instr[15:0], hold_q};
            hold_d    = in_instr[31:16];
            state_d   = in_last ? PAD : HALF;
          end
        end
      end
      PAD: begin
        if (o_free) begin
          load      = 1'b1;
          load_word = {C_NOP, hold_q};
          load_last = 1'b1;
          hold_d    = 16'h0;
          state_d   = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      hold_q  <= 16'h0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_word  <= 32'h0;
      out_addr  <= '0;
      out_last  <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_addr  <= out_last ? '0
                   : out_addr + ADDR_W'(1);
      end
      if (load) begin
        out_valid <= 1'b1;
        out_word  <= bswap32(load_word);
        out_last  <= load_last;
      end
    end
  end

endmodule
